// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM states and buffer entry layout
// for the instruction fetch unit and its instruction buffer.
package fetch_pkg;
  localparam int ADDR_W = 25;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction port between fetch (master) and
// memory controller (slave): enable/addr out, valid/result back.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 25
);
  logic                      instr_enable;
  logic [ADDR_W-1:0]         instr_addr;
  logic                      instr_valid;
  logic [fetch_pkg::XLEN-1:0] instr_result;

  modport master (
    output instr_enable, instr_addr,
    input  instr_valid, instr_result
  );

  modport slave (
    input  instr_enable, instr_addr,
    output instr_valid, instr_result
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two instruction buffer; push/pop/flush in,
// registered head, count, empty, full out. Flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T = fetch_entry_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              din,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  T mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues one fetch at a time into a reserved buffer
// slot, hands {pc,instr} to decode, squashes old stream on redirect.
module instr_fetch_unit #(
  parameter int              ADDR_W     = 25,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         bus,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  output logic [fetch_pkg::XLEN-1:0] out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  input  logic                       out_ready
);
  import fetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   instr;
  } entry_t;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redir_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  entry_t            din;
  entry_t            head;

  assign pc_inc    = fetch_pc + ADDR_W'(4);
  assign redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pop       = out_valid && out_ready && !redirect;
  assign push      = state == WAIT && bus.instr_valid && !redirect;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign din       = '{pc: fetch_pc, instr: bus.instr_result};

  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // In WAIT, fetch_pc equals the outstanding instr_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      fetch_pc         <= RESET_PC;
      bus.instr_enable <= 1'b0;
      bus.instr_addr   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redir_pc;
      unique case (state)
        WAIT, DROP: begin
          if (bus.instr_valid) begin
            state            <= IDLE;
            bus.instr_enable <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_full) begin
            state            <= WAIT;
            bus.instr_enable <= 1'b1;
            bus.instr_addr   <= fetch_pc;
          end
        end
        WAIT: begin
          if (bus.instr_valid) begin
            fetch_pc <= pc_inc;
            if (count_nxt < CW'(FIFO_DEPTH)) begin
              bus.instr_addr <= pc_inc;
            end else begin
              state            <= IDLE;
              bus.instr_enable <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.instr_valid) begin
            state            <= IDLE;
            bus.instr_enable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random-latency responder plus a stream-level
// model of expected requests and decode-side words.
module tb_instr_fetch_unit;
  localparam int AW = 25;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RPC = '0;

  typedef logic [AW-1:0] addr_t;
  typedef struct {
    addr_t       pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  addr_t       redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  addr_t       out_pc;
  logic        out_ready;

  int total = 0;
  int bad = 0;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

  instr_fetch_unit #(
    .ADDR_W     (AW),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  ent_t  exp_q[$];
  addr_t issued[$];
  addr_t popped[$];
  bit    pend, taint, ghost, new_req, want_hit, hit;
  int    cd;
  int    lat_min = 1;
  int    lat_max = 1;
  int    rbase, pbase;
  addr_t req_a, exp_next;

  function automatic addr_t at(input addr_t q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  // One clock: check outputs, play responder, drive inputs,
  // then apply the expected effect of the coming edge to the model.
  task automatic cycle(input bit rd, input addr_t tgt,
                       input bit rdy, input bit rs);
    bit          deliver;
    logic [31:0] data;
    ent_t        e;
    @(negedge clk);
    new_req = 0;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0].pc);
      check("out_instr", out_instr, exp_q[0].instr);
    end
    if (!pend && bus.instr_enable) begin
      check("req_addr", bus.instr_addr, exp_next);
      issued.push_back(bus.instr_addr);
      pend     = 1;
      taint    = 0;
      new_req  = 1;
      req_a    = bus.instr_addr;
      exp_next = req_a + AW'(4);
      cd       = $urandom_range(lat_max, lat_min) - 1;
    end else if (pend) begin
      check("req_hold", {bus.instr_enable, bus.instr_addr}, {1'b1, req_a});
    end
    check("slots", (exp_q.size() + int'(pend)) <= DEPTH, 1'b1);
    deliver = pend && cd == 0;
    if (pend && cd > 0) cd--;
    if (want_hit && deliver && out_valid && rdy) begin
      rd       = 1;
      tgt      = 'h203;
      want_hit = 0;
      hit      = 1;
    end
    data = 32'hA000_0000 | 32'(req_a);
    bus.instr_valid  = deliver | ghost;
    bus.instr_result = deliver ? data : $urandom;
    if (ghost) begin
      check("ghost_en", bus.instr_enable, 1'b0);
      ghost = 0;
    end
    rst         = rs;
    redirect    = rd;
    redirect_pc = tgt;
    out_ready   = rdy;
    if (rs) begin
      exp_q.delete();
      exp_next = RPC;
      ghost    = pend && !deliver;
      pend     = 0;
    end else if (rd) begin
      exp_q.delete();
      exp_next = {tgt[AW-1:2], 2'b00};
      rbase    = issued.size();
      pbase    = popped.size();
      if (pend && !deliver) taint = 1;
      if (deliver) pend = 0;
    end else begin
      if (out_valid && rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        popped.push_back(e.pc);
      end
      if (deliver && !taint) exp_q.push_back('{req_a, data});
      if (deliver) pend = 0;
    end
  endtask

  initial begin
    rst = 1; redirect = 0; redirect_pc = '0; out_ready = 0;
    bus.instr_valid = 0; bus.instr_result = '0;
    pend = 0; taint = 0; ghost = 0; want_hit = 0; hit = 0;
    cd = 0; req_a = '0; exp_next = RPC; rbase = 0; pbase = 0;
    repeat (2) @(negedge clk);
    check("rst_en", bus.instr_enable, 1'b0);
    check("rst_addr", bus.instr_addr, RPC);
    check("rst_ovalid", out_valid, 1'b0);
    check("rst_oinstr", out_instr, 32'h0);
    check("rst_opc", out_pc, 25'h0);
    rst = 0;

    // streaming
    lat_min = 3; lat_max = 3;
    repeat (30) cycle(0, '0, 1, 0);
    check("stream_a0", at(issued, 0), 'h0);
    check("stream_a1", at(issued, 1), 'h4);
    check("stream_a2", at(issued, 2), 'h8);
    check("stream_a3", at(issued, 3), 'hC);
    check("stream_cnt", popped.size() >= 7, 1'b1);

    // backpressure
    cycle(0, '0, 0, 1);
    pbase = issued.size();
    repeat (20) cycle(0, '0, 0, 0);
    check("bp_reqs", issued.size() - pbase, DEPTH);
    check("bp_en", bus.instr_enable, 1'b0);
    check("bp_full", out_valid, 1'b1);
    repeat (20) cycle(0, '0, 1, 0);
    check("bp_resume", at(issued, pbase + DEPTH), 4 * DEPTH);

    // redirect with request in flight
    lat_min = 6; lat_max = 6;
    cycle(0, '0, 1, 1);
    for (int i = 0; i < 40 && !(new_req && req_a == 'h8); i++)
      cycle(0, '0, 1, 0);
    check("rif_seen", new_req && req_a == 'h8, 1'b1);
    cycle(1, 'h100, 1, 0);
    repeat (25) cycle(0, '0, 1, 0);
    check("rif_next", at(issued, rbase), 'h100);
    check("rif_pop", at(popped, pbase), 'h100);

    // redirect on the same edge as instr_valid and a pop
    lat_min = 1; lat_max = 1;
    want_hit = 1; hit = 0;
    for (int i = 0; i < 50 && want_hit; i++)
      cycle(0, '0, 1, 0);
    check("coin_hit", hit, 1'b1);
    cycle(0, '0, 1, 0);
    check("coin_empty", out_valid, 1'b0);
    repeat (6) cycle(0, '0, 1, 0);
    check("coin_next", at(issued, rbase), 'h200);

    // address wrap
    lat_min = 2; lat_max = 2;
    cycle(1, 25'h1FFFFFC, 1, 0);
    repeat (12) cycle(0, '0, 1, 0);
    check("wrap0", at(issued, rbase), 25'h1FFFFFC);
    check("wrap1", at(issued, rbase + 1), 25'h0);

    // reset while a request is outstanding
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 20 && !pend; i++)
      cycle(0, '0, 1, 0);
    check("rm_pend", pend, 1'b1);
    cycle(0, '0, 1, 1);
    pbase = issued.size();
    repeat (3) cycle(0, '0, 1, 0);
    check("rm_quiet", out_valid, 1'b0);
    repeat (10) cycle(0, '0, 1, 0);
    check("rm_restart", at(issued, pbase), RPC);

    // random traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit rdy;
      r   = $urandom_range(99) < 8;
      rdy = $urandom_range(99) < 70;
      cycle(r, addr_t'($urandom_range(1023)), rdy, 0);
    end
    repeat (20) cycle(0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
